if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage. Owns the PC and runs a request/acknowledge fetch handshake to instruction memory.
- Presents a registered {pc, inst, valid} to the decode stage.
- Honours the downstream stall, and takes branch redirects that flush and discard in-flight fetches.
- Upstream of decode; replaces the separate pc register and fetch/decode pipeline register.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; low 2 bits must be 0.
- ADDR_W, 32, width of PC and instruction address (InstAddrBus).
- INST_W, 32, instruction width (InstBus).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- stall_i  in  1  decode cannot accept; output must hold.
- branch_flag_i  in  1  one-cycle redirect request.
- branch_target_i  in  ADDR_W  redirect address.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  ADDR_W  fetch address.
- imem_ack_i  in  1  read data valid this cycle; may be asserted in the same cycle as req.
- imem_rdata_i  in  INST_W  instruction word.
- id_pc_o  out  ADDR_W  PC of the presented instruction.
- id_inst_o  out  INST_W  presented instruction.
- id_valid_o  out  1  id_pc_o and id_inst_o are valid.

Behaviour:
- Reset (rst=1 at an edge):
  - pc=RESET_PC, state=S_IDLE, skid buffer empty.
  - id_valid_o=0, id_pc_o=0, id_inst_o=0 (ZeroWord; decode sees a NOP).
  - imem_req_o=0, imem_addr_o=0.
  - Reset mid-fetch abandons the transaction; a late ack after reset is ignored (state S_IDLE).
- States:
  - S_IDLE: one cycle after reset, then go to S_REQ.
  - S_REQ: fetching.
  - S_DROP: waiting to discard a flushed in-flight fetch.
- S_REQ requests:
  - imem_req_o=1 only when the skid buffer is empty; imem_addr_o=pc.
  - Address is held stable while req=1 and ack=0.
- Ack in S_REQ, no branch:
  - Word = {pc, imem_rdata_i}; pc<=pc+4, wrapping 32'hFFFF_FFFC to 0.
  - If the output register is free (id_valid_o=0, or stall_i=0 so it is being consumed), the word loads into the output: id_valid_o=1.
  - Otherwise the word goes to the 1-entry skid buffer and req drops next cycle.
- Consumption:
  - The output is consumed at an edge where id_valid_o=1 and stall_i=0.
  - The next output is the skid entry if present, else a simultaneous ack word, else id_valid_o<=0.
- Stall: id_pc_o, id_inst_o and id_valid_o hold exactly while stall_i=1.
- Throughput: with a zero-wait memory (ack same cycle as req) and no stall, one instruction per cycle. The first id_valid_o=1 appears 2 cycles after rst deasserts.
- Branch (branch_flag_i=1 at an edge, priority over stall and ack):
  - pc<=branch_target_i with bits[1:0] forced to 0.
  - id_valid_o<=0 and the skid buffer is cleared.
  - If req=1 and ack=0 that cycle, the fetch is in flight: go to S_DROP.
  - If ack=1 that same cycle, the returned word is discarded and state stays S_REQ.
- S_DROP:
  - Keeps req=1 and addr at the old address until ack; the data is discarded.
  - Then goes to S_REQ, fetching the branch target.
  - A further branch in S_DROP only updates pc.
- Invariants:
  - Never more than 2 words held (output + skid).
  - The PC sequence presented to decode is strictly sequential except across a branch.

Decomposition:
- Shared define/package: InstAddrBus, InstBus, RstEnable, ZeroWord, WriteEnable/Disable, and the state encodings S_IDLE/S_REQ/S_DROP (2-bit).
- One sub-module, if_id_skid: the output register plus 1-entry skid buffer with flush. Interface: push valid/data in, stall in, flush in, registered outputs, full flag.
- The FSM and PC stay in if_stage.

Test Plan:
- Reset then zero-wait memory (ack=req), no stall:
  - id_pc_o is 0x0, 0x4, 0x8 on consecutive cycles with matching rdata; first valid 2 cycles after rst deasserts.
- Stall held 3 cycles while acks continue:
  - Output frozen at pc 0x8.
  - Skid captures pc 0xC; req drops after the skid fills.
  - On release, 0xC then 0x10 are presented with no gap or duplicate.
- Memory with 2-cycle ack latency:
  - imem_addr_o stable during the wait.
  - id_valid_o toggles 1 instruction per 3 cycles; PCs stay sequential.
- Branch to 0x0000_0103 while a fetch at 0x14 is in flight (ack 2 cycles later):
  - Output flushed; the 0x14 data is never presented.
  - Next request address is 0x100; next id_pc_o is 0x100.
- Branch coincident with ack and with stall_i=1:
  - Ack data is dropped; id_valid_o=0 next cycle.
  - Fetch resumes at the target regardless of stall.
- PC at 0xFFFF_FFFC with ack and reset asserted mid-fetch:
  - Next PC wraps to 0x0.
  - After reset: all outputs 0, first request at RESET_PC, late ack ignored.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its
// fetch/decode output buffer.
package if_stage_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic RstEnable    = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic [InstBus-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DROP = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/if_id_skid.sv
// Registered fetch/decode output word plus a one-entry skid buffer that
// absorbs a word returning while decode is stalled. Flush empties both.
module if_id_skid
  import if_stage_pkg::*;
#(
  parameter int ADDR_W = InstAddrBus,
  parameter int INST_W = InstBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] pushPc_i,
  input  logic [INST_W-1:0] pushInst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              outValid_o,
  output logic [ADDR_W-1:0] outPc_o,
  output logic [INST_W-1:0] outInst_o,
  output logic              full_o
);

  logic              outValid_q, outValid_d;
  logic [ADDR_W-1:0] outPc_q, outPc_d;
  logic [INST_W-1:0] outInst_q, outInst_d;
  logic              skidValid_q, skidValid_d;
  logic [ADDR_W-1:0] skidPc_q, skidPc_d;
  logic [INST_W-1:0] skidInst_q, skidInst_d;
  logic              outFree;

  // The output slot can take a new word when empty or being consumed.
  assign outFree = !outValid_q || !stall_i;

  always_comb begin
    outValid_d  = outValid_q;
    outPc_d     = outPc_q;
    outInst_d   = outInst_q;
    skidValid_d = skidValid_q;
    skidPc_d    = skidPc_q;
    skidInst_d  = skidInst_q;
    if (flush_i) begin
      outValid_d  = WriteDisable;
      skidValid_d = WriteDisable;
    end else if (outFree) begin
      if (skidValid_q) begin
        outValid_d  = WriteEnable;
        outPc_d     = skidPc_q;
        outInst_d   = skidInst_q;
        skidValid_d = WriteDisable;
      end else if (push_i) begin
        outValid_d = WriteEnable;
        outPc_d    = pushPc_i;
        outInst_d  = pushInst_i;
      end else begin
        outValid_d = WriteDisable;
      end
    end else if (push_i && !skidValid_q) begin
      skidValid_d = WriteEnable;
      skidPc_d    = pushPc_i;
      skidInst_d  = pushInst_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      outValid_q  <= WriteDisable;
      outPc_q     <= '0;
      outInst_q   <= INST_W'(ZeroWord);
      skidValid_q <= WriteDisable;
      skidPc_q    <= '0;
      skidInst_q  <= INST_W'(ZeroWord);
    end else begin
      outValid_q  <= outValid_d;
      outPc_q     <= outPc_d;
      outInst_q   <= outInst_d;
      skidValid_q <= skidValid_d;
      skidPc_q    <= skidPc_d;
      skidInst_q  <= skidInst_d;
    end
  end

  assign outValid_o = outValid_q;
  assign outPc_o    = outPc_q;
  assign outInst_o  = outInst_q;
  assign full_o     = skidValid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs the req/ack handshake to
// instruction memory and hands registered {pc, inst, valid} to decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                ADDR_W   = InstAddrBus,
  parameter int                INST_W   = InstBus,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              id_valid_o
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] dropAddr_q, dropAddr_d;
  logic              skidFull;
  logic              fetchAck;
  logic              pushWord;

  // While draining a flushed fetch the bus must keep showing its old address.
  always_comb begin
    imem_req_o  = 1'b0;
    imem_addr_o = '0;
    case (state_q)
      S_REQ: begin
        imem_req_o  = !skidFull;
        imem_addr_o = pc_q;
      end
      S_DROP: begin
        imem_req_o  = 1'b1;
        imem_addr_o = dropAddr_q;
      end
      default: ;
    endcase
  end

  assign fetchAck = (state_q == S_REQ) && imem_req_o && imem_ack_i;
  assign pushWord = fetchAck && !branch_flag_i;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    dropAddr_d = dropAddr_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (branch_flag_i) begin
          if (imem_req_o && !imem_ack_i) begin
            state_d    = S_DROP;
            dropAddr_d = pc_q;
          end
        end else if (fetchAck) begin
          pc_d = pc_q + ADDR_W'(4);
        end
      end
      S_DROP: if (imem_ack_i) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
    if (branch_flag_i) pc_d = {branch_target_i[ADDR_W-1:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      dropAddr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      dropAddr_q <= dropAddr_d;
    end
  end

  if_id_skid #(
    .ADDR_W(ADDR_W),
    .INST_W(INST_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push_i     (pushWord),
    .pushPc_i   (pc_q),
    .pushInst_i (imem_rdata_i),
    .stall_i    (stall_i),
    .flush_i    (branch_flag_i),
    .outValid_o (id_valid_o),
    .outPc_o    (id_pc_o),
    .outInst_o  (id_inst_o),
    .full_o     (skidFull)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a variable-latency memory model and an
// in-order scoreboard of every word that decode should see.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branchFlag = 1'b0;
  logic [31:0] branchTarget = '0;
  logic        imemAck = 1'b0;
  logic [31:0] imemRdata = '0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] idPc;
  logic [31:0] idInst;
  logic        idValid;

  always #5 clk = ~clk;

  if_stage #(
    .ADDR_W  (32),
    .INST_W  (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall),
    .branch_flag_i  (branchFlag),
    .branch_target_i(branchTarget),
    .imem_req_o     (imemReq),
    .imem_addr_o    (imemAddr),
    .imem_ack_i     (imemAck),
    .imem_rdata_i   (imemRdata),
    .id_pc_o        (idPc),
    .id_inst_o      (idInst),
    .id_valid_o     (idValid)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } word_t;

  word_t       expQ[$];
  int          checkCount = 0;
  int          passCount = 0;
  int          failCount = 0;
  int          latency = 0;
  int          waitCnt = 0;
  bit          dropping = 1'b0;
  bit          heldEdge = 1'b0;
  logic [31:0] heldPc = '0;
  logic [31:0] heldInst = '0;

  function automatic logic [31:0] instFor(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock: drive inputs, answer the memory, advance, then score the output.
  task automatic applyStimulus(input logic rstV, input logic st, input logic br,
                               input logic [31:0] tgt, input logic lateAck);
    word_t w;
    heldEdge = (idValid === 1'b1) && st && !br && !rstV;
    heldPc   = idPc;
    heldInst = idInst;
    rst          = rstV;
    stall        = st;
    branchFlag   = br;
    branchTarget = tgt;
    #1;
    if (lateAck) begin
      imemAck   = 1'b1;
      imemRdata = 32'hBAD0_ACC5;
    end else if (imemReq === 1'b1) begin
      if (waitCnt >= latency) begin
        imemAck   = 1'b1;
        imemRdata = instFor(imemAddr);
        waitCnt   = 0;
      end else begin
        imemAck   = 1'b0;
        imemRdata = 32'hDEAD_BEEF;
        waitCnt++;
      end
    end else begin
      imemAck = 1'b0;
      waitCnt = 0;
    end
    if (rstV) begin
      expQ.delete();
      dropping = 1'b0;
      waitCnt  = 0;
    end else if (br) begin
      expQ.delete();
      if (imemReq === 1'b1) dropping = !imemAck;
    end else if (imemReq === 1'b1 && imemAck) begin
      if (dropping) dropping = 1'b0;
      else expQ.push_back({imemAddr, imemRdata});
    end
    @(posedge clk);
    #1;
    if (heldEdge) begin
      checkOutput("hold_valid", 32'(idValid), 32'd1);
      checkOutput("hold_pc", idPc, heldPc);
      checkOutput("hold_inst", idInst, heldInst);
    end else if (idValid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_valid", 32'(idValid), 32'd0);
      end else begin
        w = expQ.pop_front();
        checkOutput("sb_pc", idPc, w.pc);
        checkOutput("sb_inst", idInst, w.inst);
      end
    end
  endtask

  initial begin
    $display("[TB] if_stage bench start");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("rst_valid", 32'(idValid), 32'd0);
    checkOutput("rst_pc", idPc, 32'h0);
    checkOutput("rst_inst", idInst, 32'h0);
    checkOutput("rst_req", 32'(imemReq), 32'd0);
    checkOutput("rst_addr", imemAddr, 32'h0);

    // Zero-wait memory, no stall.
    latency = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("c1_valid", 32'(idValid), 32'd0);
    checkOutput("c1_req", 32'(imemReq), 32'd1);
    checkOutput("c1_addr", imemAddr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("seq_valid", 32'(idValid), 32'd1);
      checkOutput("seq_pc", idPc, 32'(4 * i));
    end

    // Three-cycle stall while the memory keeps answering.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput("stall_pc", idPc, 32'h8);
      checkOutput("stall_req", 32'(imemReq), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("release_pc", idPc, 32'hC);
    checkOutput("release_req", 32'(imemReq), 32'd1);
    checkOutput("release_addr", imemAddr, 32'h10);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("release_next", idPc, 32'h10);

    // Branch while the fetch at 0x14 is still waiting for its ack.
    latency = 2;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("wait_valid", 32'(idValid), 32'd0);
    checkOutput("wait_addr", imemAddr, 32'h14);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b0);
    checkOutput("br_flush_valid", 32'(idValid), 32'd0);
    checkOutput("drop_req", 32'(imemReq), 32'd1);
    checkOutput("drop_addr", imemAddr, 32'h14);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("br_valid", 32'(idValid), 32'd0);
    checkOutput("br_addr", imemAddr, 32'h100);

    // Two-cycle ack latency: one word per three cycles, address held.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("lat_valid", 32'(idValid), 32'((k % 3) == 2));
      checkOutput("lat_addr", imemAddr, 32'h100 + 32'(4 * ((k + 1) / 3)));
    end

    // Branch in the same cycle as an ack, with decode stalled.
    latency = 0;
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
    checkOutput("bs_valid", 32'(idValid), 32'd0);
    checkOutput("bs_req", 32'(imemReq), 32'd1);
    checkOutput("bs_addr", imemAddr, 32'h200);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("bs_resume_valid", 32'(idValid), 32'd1);
    checkOutput("bs_resume_pc", idPc, 32'h200);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("bs_next_pc", idPc, 32'h204);

    // PC wrap at the top of the address space.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    checkOutput("wrap_addr", imemAddr, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("wrap_pc", idPc, 32'hFFFF_FFFC);
    checkOutput("wrap_next_addr", imemAddr, 32'h0);

    // Reset in the middle of a slow fetch, then a stray ack in idle.
    latency = 2;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("mid_req", 32'(imemReq), 32'd1);
    checkOutput("mid_valid", 32'(idValid), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("rst2_valid", 32'(idValid), 32'd0);
    checkOutput("rst2_pc", idPc, 32'h0);
    checkOutput("rst2_inst", idInst, 32'h0);
    checkOutput("rst2_req", 32'(imemReq), 32'd0);
    checkOutput("rst2_addr", imemAddr, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("late_valid", 32'(idValid), 32'd0);
    checkOutput("post_req", 32'(imemReq), 32'd1);
    checkOutput("post_addr", imemAddr, 32'h0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("post_valid", 32'(idValid), 32'(k == 2));
    end
    checkOutput("post_pc", idPc, 32'h0);
    checkOutput("sb_drained", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
